// File: rtl/tx_buffer_memory_pkg.sv
// Shared types, constants and byte-mask helpers for the TX packet buffer.
package tx_buffer_pkg;

  typedef enum logic [1:0] {
    e_op_1b = 2'd0,
    e_op_2b = 2'd1,
    e_op_4b = 2'd2,
    e_op_8b = 2'd3
  } op_size_e;

  localparam int unsigned els_lp        = 2048;
  localparam int unsigned addr_width_lp = 11;
  localparam int unsigned size_width_lp = 16;

  // Force a byte offset down to the natural alignment of the op size.
  function automatic logic [2:0] align_off(input logic [1:0] op, input logic [2:0] off);
    logic [2:0] lo;
    lo = (3'd1 << op) - 3'd1;   // op=3 wraps to 3'b111, clearing all offset bits
    return off & ~lo;
  endfunction

  // Byte-enable mask: 2^op bytes set starting at the aligned offset.
  function automatic logic [7:0] byte_mask(input logic [1:0] op, input logic [2:0] off);
    logic [15:0] m;
    m = ((16'd1 << (16'd1 << op)) - 16'd1) << align_off(op, off);
    return m[7:0];
  endfunction

endpackage

// File: rtl/tx_buffer_memory_mem.sv
// Single-port synchronous RAM with per-byte write enables; registered read port.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int unsigned els_p        = 256,
  parameter int unsigned data_width_p = 64,
  parameter int unsigned addr_width_p = $clog2(els_p),
  localparam int unsigned mask_w_lp   = data_width_p / 8
) (
  input  logic                    clk_i,
  input  logic                    v_i,
  input  logic                    w_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic [mask_w_lp-1:0]    write_mask_i,
  output logic [data_width_p-1:0] data_o
);

  logic [data_width_p-1:0] mem_q [els_p];
  logic [data_width_p-1:0] data_q;

  // Byte-masked write; untouched lanes keep their contents.
  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      for (int b = 0; b < int'(mask_w_lp); b++) begin
        if (write_mask_i[b]) mem_q[addr_i][8*b +: 8] <= data_i[8*b +: 8];
      end
    end
  end

  // Read data lands one cycle after the request and is held otherwise.
  always_ff @(posedge clk_i) begin
    if (v_i & ~w_i) data_q <= mem_q[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/tx_buffer_memory_slot_tracker.sv
// FIFO slot bookkeeping: write/read slot pointers, occupancy, full/empty.
module tx_slot_tracker #(
  parameter int unsigned slot_p  = 2,
  localparam int unsigned ptr_w_lp = $clog2(slot_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                enq_i,    // already gated by ~full
  input  logic                deq_i,    // already gated by ~empty
  output logic [ptr_w_lp-1:0] wptr_o,
  output logic [ptr_w_lp-1:0] rptr_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ptr_w_lp:0]   cnt_q, cnt_d;

  // Next-state: pointers wrap naturally since slot_p is a power of two.
  always_comb begin
    wptr_d = enq_i ? ptr_w_lp'(wptr_q + 1'b1) : wptr_q;
    rptr_d = deq_i ? ptr_w_lp'(rptr_q + 1'b1) : rptr_q;
    cnt_d  = cnt_q;
    case ({enq_i, deq_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset drops every slot, committed or not.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign full_o  = (cnt_q == (ptr_w_lp+1)'(slot_p));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/tx_buffer_memory.sv
// Multi-slot TX packet buffer: PL fills/commits slots, MAC reads/releases them in order.
module tx_buffer_memory import tx_buffer_pkg::*; #(
  parameter int unsigned slot_p       = 2,
  parameter int unsigned data_width_p = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  output logic                     write_slot_ready_and_o,
  input  logic                     write_v_i,
  input  logic [addr_width_lp-1:0] write_addr_i,
  input  logic [1:0]               write_op_size_i,
  input  logic [data_width_p-1:0]  write_data_i,
  input  logic                     send_v_i,
  input  logic [size_width_lp-1:0] send_size_i,
  output logic                     read_slot_v_o,
  output logic [size_width_lp-1:0] read_size_r_o,
  input  logic                     read_v_i,
  input  logic [addr_width_lp-1:0] read_addr_i,
  output logic [data_width_p-1:0]  read_data_o,
  output logic                     read_data_v_o,
  input  logic                     read_slot_ready_and_i
);

  localparam int unsigned nb_lp       = data_width_p / 8;
  localparam int unsigned lg_nb_lp    = $clog2(nb_lp);
  localparam int unsigned word_els_lp = els_lp / nb_lp;
  localparam int unsigned word_aw_lp  = addr_width_lp - lg_nb_lp;
  localparam int unsigned ptr_w_lp    = $clog2(slot_p);

  logic                             full, empty;
  logic [ptr_w_lp-1:0]              wptr, rptr;
  logic                             st_acc, cm_acc, rd_acc, rl_acc;
  logic [2:0]                       woff, woff_al;
  logic [7:0]                       wmask8;
  logic [nb_lp-1:0]                 wmask;
  logic [data_width_p-1:0]          wdata;
  logic [word_aw_lp-1:0]            waddr, raddr;
  logic [slot_p-1:0][data_width_p-1:0]  mem_data;
  logic [slot_p-1:0][size_width_lp-1:0] size_q;
  logic [ptr_w_lp-1:0]              rslot_q;
  logic                             rdv_q;
  logic [data_width_p-1:0]          rhold_q;

  // All port actions use the pre-cycle full/empty flags.
  assign st_acc = write_v_i & ~full;
  assign cm_acc = send_v_i & ~full;
  assign rd_acc = read_v_i & ~empty;
  assign rl_acc = read_slot_ready_and_i & ~empty;

  assign woff    = 3'(write_addr_i[lg_nb_lp-1:0]);
  assign woff_al = align_off(write_op_size_i, woff);
  assign wmask8  = byte_mask(write_op_size_i, woff);
  assign wmask   = wmask8[nb_lp-1:0];
  assign wdata   = write_data_i << {woff_al, 3'b000};
  assign waddr   = write_addr_i[addr_width_lp-1:lg_nb_lp];
  assign raddr   = read_addr_i[addr_width_lp-1:lg_nb_lp];

  tx_slot_tracker #(.slot_p(slot_p)) u_trk (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enq_i     (cm_acc),
    .deq_i     (rl_acc),
    .wptr_o    (wptr),
    .rptr_o    (rptr),
    .full_o    (full),
    .empty_o   (empty)
  );

  // One RAM per slot; write and head slot never collide while both ports are live.
  for (genvar s = 0; s < int'(slot_p); s++) begin : g_slot
    logic                  rd_en, wr_en;
    logic [word_aw_lp-1:0] addr;
    assign rd_en = rd_acc & (rptr == ptr_w_lp'(s));
    assign wr_en = st_acc & (wptr == ptr_w_lp'(s));
    // Head slot takes the read address only when it is actually being read,
    // so an empty buffer (head == write slot) still accepts stores.
    assign addr  = rd_en ? raddr : waddr;

    bsg_mem_1rw_sync_mask_write_byte #(
      .els_p        (word_els_lp),
      .data_width_p (data_width_p),
      .addr_width_p (word_aw_lp)
    ) u_mem (
      .clk_i        (clk_i),
      .v_i          (rd_en | wr_en),
      .w_i          (wr_en),
      .addr_i       (addr),
      .data_i       (wdata),
      .write_mask_i (wmask),
      .data_o       (mem_data[s])
    );
  end

  // Latch the packet length into the slot being committed.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      size_q <= '0;
    end else begin
      for (int s = 0; s < int'(slot_p); s++) begin
        if (cm_acc && (wptr == ptr_w_lp'(s))) size_q[s] <= send_size_i;
      end
    end
  end

  // Register the issuing slot so a same-cycle release still returns its data.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rdv_q   <= 1'b0;
      rslot_q <= '0;
    end else begin
      rdv_q <= rd_acc;
      if (rd_acc) rslot_q <= rptr;
    end
  end

  // Output hold register keeps the last returned word between reads.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rhold_q <= '0;
    else if (rdv_q) rhold_q <= mem_data[rslot_q];
  end

  assign read_data_o            = rdv_q ? mem_data[rslot_q] : rhold_q;
  assign read_data_v_o          = rdv_q;
  assign write_slot_ready_and_o = ~full;
  assign read_slot_v_o          = ~empty;
  assign read_size_r_o          = size_q[rptr];

`ifndef SYNTHESIS
  a_width: assert property (@(posedge clk_i) (data_width_p == 32) || (data_width_p == 64));
  a_align: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    write_v_i |-> ((3'(write_addr_i[2:0]) & ((3'd1 << write_op_size_i) - 3'd1)) == 3'd0));
  a_opsz: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    write_v_i |-> ((32'd1 << write_op_size_i) <= nb_lp));
  a_size: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    send_v_i |-> ((send_size_i != '0) && (send_size_i <= size_width_lp'(els_lp))));
  logic unused_rd_lo;
  assign unused_rd_lo = ^read_addr_i[lg_nb_lp-1:0];
`endif

endmodule

// File: tb/tb_tx_buffer_memory.sv
// Self-checking bench: byte-array model of the slot FIFO, per-cycle compare plus directed literals.
module tb_tx_buffer_memory;
  localparam int S = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wr_rdy, slot_v, rdv;
  logic [15:0] rsize;
  logic [63:0] rdata;
  logic        write_v = 0, send_v = 0, read_v = 0, rel = 0;
  logic [10:0] write_addr = 0, read_addr = 0;
  logic [1:0]  write_op = 0;
  logic [63:0] write_data = 0;
  logic [15:0] send_size = 0;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  tx_buffer_memory #(.slot_p(S), .data_width_p(64)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .write_slot_ready_and_o(wr_rdy),
    .write_v_i(write_v), .write_addr_i(write_addr), .write_op_size_i(write_op),
    .write_data_i(write_data), .send_v_i(send_v), .send_size_i(send_size),
    .read_slot_v_o(slot_v), .read_size_r_o(rsize),
    .read_v_i(read_v), .read_addr_i(read_addr),
    .read_data_o(rdata), .read_data_v_o(rdv),
    .read_slot_ready_and_i(rel)
  );

  // ---------------- behavioural model ----------------
  logic [7:0]  mmem [S][2048];
  bit          mkn  [S][2048];
  logic [15:0] msize [S];
  int          mcnt, mwr, mrd;
  bit          exp_v;
  logic [63:0] exp_d, exp_k;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt = 0; mwr = 0; mrd = 0; exp_v = 0; exp_d = 0; exp_k = '1;
    end else begin
      bit c, r;
      exp_v = 0;
      if (read_v && mcnt > 0) begin
        int base;
        base = (int'(read_addr) / 8) * 8;
        for (int k = 0; k < 8; k++) begin
          exp_d[8*k +: 8] = mmem[mrd][base+k];
          exp_k[8*k +: 8] = mkn[mrd][base+k] ? 8'hFF : 8'h00;
        end
        exp_v = 1;
      end
      if (write_v && mcnt < S) begin
        int n, base;
        n    = 1 << write_op;
        base = (int'(write_addr) / n) * n;
        for (int k = 0; k < n; k++) begin
          mmem[mwr][base+k] = write_data[8*k +: 8];
          mkn[mwr][base+k]  = 1;
        end
      end
      c = send_v && mcnt < S;
      r = rel && mcnt > 0;
      if (c) begin msize[mwr] = send_size; mwr = (mwr + 1) % S; end
      if (r) mrd = (mrd + 1) % S;
      mcnt = mcnt + int'(c) - int'(r);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("ready", 64'(wr_rdy), 64'(mcnt < S));
      check("slot_v", 64'(slot_v), 64'(mcnt > 0));
      if (mcnt > 0) check("size", 64'(rsize), 64'(msize[mrd]));
      check("rdv", 64'(rdv), 64'(exp_v));
      check("rdata", rdata & exp_k, exp_d & exp_k);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit wv, input logic [10:0] wa, input logic [1:0] wo,
                       input logic [63:0] wd, input bit sv, input logic [15:0] ss,
                       input bit rv, input logic [10:0] ra, input bit rl);
    write_v = wv; write_addr = wa; write_op = wo; write_data = wd;
    send_v = sv; send_size = ss; read_v = rv; read_addr = ra; rel = rl;
    @(negedge clk);
    write_v = 0; send_v = 0; read_v = 0; rel = 0;
  endtask

  task automatic store(input logic [10:0] a, input logic [1:0] o, input logic [63:0] d);
    drive(1, a, o, d, 0, 0, 0, 0, 0);
  endtask
  task automatic commit(input logic [15:0] s);
    drive(0, 0, 0, 0, 1, s, 0, 0, 0);
  endtask
  task automatic rd(input logic [10:0] a, input bit rl);
    drive(0, 0, 0, 0, 0, 0, 1, a, rl);
  endtask
  task automatic release_slot();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(wr_rdy), 64'd1);
    check("rst_slot_v", 64'(slot_v), 64'd0);
    check("rst_size", 64'(rsize), 64'd0);
    check("rst_rdv", 64'(rdv), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);

    // Single 8-byte packet
    store(0, 3, 64'h1122334455667788);
    commit(8);
    check("t1_slot_v", 64'(slot_v), 64'd1);
    check("t1_size", 64'(rsize), 64'd8);
    rd(0, 0);
    check("t1_rdv", 64'(rdv), 64'd1);
    check("t1_data", rdata, 64'h1122334455667788);
    @(negedge clk);
    check("t1_hold_v", 64'(rdv), 64'd0);
    check("t1_hold", rdata, 64'h1122334455667788);

    // Byte lanes into slot 1
    store(0, 3, 64'h0);
    store(3, 0, 64'hAA);
    store(6, 1, 64'hBBCC);
    commit(16);
    release_slot();
    check("t2_size", 64'(rsize), 64'd16);
    rd(0, 1);  // read and release together: last slot
    check("t2_data", rdata, 64'hBBCC0000AA000000);
    check("t2_slot_v", 64'(slot_v), 64'd0);

    // Store+commit same cycle, then fill to full
    drive(1, 8, 3, 64'hCAFEF00D12345678, 1, 16, 0, 0, 0);
    store(0, 3, 64'h0123456789ABCDEF);
    commit(24);
    check("t3_full", 64'(wr_rdy), 64'd0);
    store(0, 3, 64'hDEADDEADDEADDEAD);
    commit(99);
    check("t3_still_full", 64'(wr_rdy), 64'd0);
    check("t3_head_size", 64'(rsize), 64'd16);
    rd(8, 0);
    check("t3_word1", rdata, 64'hCAFEF00D12345678);
    release_slot();
    check("t3_ready", 64'(wr_rdy), 64'd1);
    check("t3_size2", 64'(rsize), 64'd24);
    rd(0, 0);
    check("t3_next_slot", rdata, 64'h0123456789ABCDEF);

    // Commit and release together while full
    commit(40);
    drive(0, 0, 0, 0, 1, 50, 0, 0, 1);
    check("t4_ready", 64'(wr_rdy), 64'd1);
    check("t4_slot_v", 64'(slot_v), 64'd1);
    check("t4_size", 64'(rsize), 64'd40);
    release_slot();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  o;
      logic [10:0] a;
      o = 2'($urandom_range(0, 3));
      a = 11'($urandom_range(0, 2047)) & ~((11'd1 << o) - 11'd1);
      drive($urandom_range(0, 1) == 1, a, o, {$urandom, $urandom},
            $urandom_range(0, 9) == 0, 16'($urandom_range(1, 2048)),
            $urandom_range(0, 2) == 0, 11'($urandom_range(0, 2047)),
            $urandom_range(0, 9) == 0);
    end

    // Mid-operation reset with two committed slots
    while (!slot_v) commit(7);
    while (wr_rdy) commit(9);
    read_v = 1; read_addr = 0;
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    read_v = 0;
    check("t5_slot_v", 64'(slot_v), 64'd0);
    check("t5_rdv", 64'(rdv), 64'd0);
    check("t5_ready", 64'(wr_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
